// File: rtl/dp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dp_issue_ctrl
// Description : Three-cycle issue/writeback controller for ARM data-processing
//               instructions. Holds R0-R15 and NZCV around an external ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] alu_a,
    output logic [31:0] shift_data,
    output logic [7:0]  shift_num,
    output logic [2:0]  shift_op,
    output logic [3:0]  alu_op,
    output logic [3:0]  flags,
    input  logic [31:0] alu_f,
    input  logic [3:0]  alu_nzcv,
    output logic        done,
    output logic        executed,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];
    logic [3:0]  flags_q, flags_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  res_nzcv_q, res_nzcv_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] shift_data_q, shift_data_d;
    logic [7:0]  shift_num_q, shift_num_d;
    logic [2:0]  shift_op_q, shift_op_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        done_q, done_d;
    logic        executed_q, executed_d;
    logic        illegal_q, illegal_d;

    logic        w_cond_pass;
    logic        w_illegal;
    logic        w_is_test;
    logic        w_n, w_z, w_c, w_v;

    assign w_n       = flags_q[3];
    assign w_z       = flags_q[2];
    assign w_c       = flags_q[1];
    assign w_v       = flags_q[0];
    assign w_illegal = (instr_q[27:26] != 2'b00);
    assign w_is_test = (instr_q[24:23] == 2'b10);

    always_comb begin
        w_cond_pass = 1'b0;
        case (instr_q[31:28])
            4'h0: w_cond_pass = w_z;
            4'h1: w_cond_pass = !w_z;
            4'h2: w_cond_pass = w_c;
            4'h3: w_cond_pass = !w_c;
            4'h4: w_cond_pass = w_n;
            4'h5: w_cond_pass = !w_n;
            4'h6: w_cond_pass = w_v;
            4'h7: w_cond_pass = !w_v;
            4'h8: w_cond_pass = w_c && !w_z;
            4'h9: w_cond_pass = !w_c || w_z;
            4'hA: w_cond_pass = (w_n == w_v);
            4'hB: w_cond_pass = (w_n != w_v);
            4'hC: w_cond_pass = !w_z && (w_n == w_v);
            4'hD: w_cond_pass = w_z || (w_n != w_v);
            4'hE: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        regs_d       = regs_q;
        flags_d      = flags_q;
        res_d        = res_q;
        res_nzcv_d   = res_nzcv_q;
        alu_a_d      = alu_a_q;
        shift_data_d = shift_data_q;
        shift_num_d  = shift_num_q;
        shift_op_d   = shift_op_q;
        alu_op_d     = alu_op_q;
        done_d       = 1'b0;
        executed_d   = 1'b0;
        illegal_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Operands are latched on acceptance so they are stable for all of EXEC.
                if (instr_valid) begin
                    instr_d  = instr;
                    state_d  = ST_EXEC;
                    alu_a_d  = regs_q[instr[19:16]];
                    alu_op_d = instr[24:21];
                    if (instr[25]) begin
                        shift_data_d = {24'b0, instr[7:0]};
                        shift_num_d  = {3'b0, instr[11:8], 1'b0};
                        shift_op_d   = 3'b111;
                    end else if (!instr[4]) begin
                        shift_data_d = regs_q[instr[3:0]];
                        shift_num_d  = {3'b0, instr[11:7]};
                        shift_op_d   = {instr[6:5], 1'b0};
                    end else begin
                        shift_data_d = regs_q[instr[3:0]];
                        shift_num_d  = regs_q[instr[11:8]][7:0];
                        shift_op_d   = {instr[6:5], 1'b1};
                    end
                end
            end
            ST_EXEC: begin
                res_d      = alu_f;
                res_nzcv_d = alu_nzcv;
                done_d     = 1'b1;
                executed_d = w_cond_pass;
                illegal_d  = w_illegal;
                state_d    = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
                if (w_cond_pass && !w_illegal) begin
                    if (!w_is_test) begin
                        regs_d[instr_q[15:12]] = res_q;
                    end
                    if (instr_q[20] || w_is_test) begin
                        flags_d = res_nzcv_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            instr_q      <= 32'd0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 32'd0;
            end
            flags_q      <= 4'd0;
            res_q        <= 32'd0;
            res_nzcv_q   <= 4'd0;
            alu_a_q      <= 32'd0;
            shift_data_q <= 32'd0;
            shift_num_q  <= 8'd0;
            shift_op_q   <= 3'd0;
            alu_op_q     <= 4'd0;
            done_q       <= 1'b0;
            executed_q   <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            regs_q       <= regs_d;
            flags_q      <= flags_d;
            res_q        <= res_d;
            res_nzcv_q   <= res_nzcv_d;
            alu_a_q      <= alu_a_d;
            shift_data_q <= shift_data_d;
            shift_num_q  <= shift_num_d;
            shift_op_q   <= shift_op_d;
            alu_op_q     <= alu_op_d;
            done_q       <= done_d;
            executed_q   <= executed_d;
            illegal_q    <= illegal_d;
        end
    end

    // A reset arriving during WB suppresses the retirement pulse in that same cycle.
    assign done        = done_q && !rst;
    assign executed    = executed_q && !rst;
    assign illegal     = illegal_q && !rst;
    assign instr_ready = (state_q == ST_IDLE);
    assign alu_a       = alu_a_q;
    assign shift_data  = shift_data_q;
    assign shift_num   = shift_num_q;
    assign shift_op    = shift_op_q;
    assign alu_op      = alu_op_q;
    assign flags       = flags_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_dp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_issue_ctrl
// Description : Directed bench for dp_issue_ctrl with a behavioural ALU and a
//               retirement scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_a;
    logic [31:0] shift_data;
    logic [7:0]  shift_num;
    logic [2:0]  shift_op;
    logic [3:0]  alu_op;
    logic [3:0]  flags;
    logic [31:0] alu_f;
    logic [3:0]  alu_nzcv;
    logic        done;
    logic        executed;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    dp_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .shift_data  (shift_data),
        .shift_num   (shift_num),
        .shift_op    (shift_op),
        .alu_op      (alu_op),
        .flags       (flags),
        .alu_f       (alu_f),
        .alu_nzcv    (alu_nzcv),
        .done        (done),
        .executed    (executed),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: rotate-immediate / LSL shifter plus MOV, ADD, SUB, CMP, CMN.
    logic [31:0] op2;
    logic        sh_c;
    logic [32:0] sum;
    logic        av;
    always_comb begin
        op2  = shift_data;
        sh_c = flags[1];
        sum  = {1'b0, shift_data};
        av   = flags[0];
        if (shift_op == 3'b111) begin
            if (shift_num[4:0] != 5'd0) begin
                op2  = (shift_data >> shift_num[4:0]) |
                       (shift_data << (6'd32 - {1'b0, shift_num[4:0]}));
                sh_c = op2[31];
            end
        end else if (shift_op[2:1] == 2'b00) begin
            op2 = shift_data << shift_num[4:0];
        end
        case (alu_op)
            4'd2, 4'd10: begin
                sum = {1'b0, alu_a} + {1'b0, ~op2} + 33'd1;
                av  = (alu_a[31] != op2[31]) && (sum[31] != alu_a[31]);
            end
            4'd4, 4'd11: begin
                sum = {1'b0, alu_a} + {1'b0, op2};
                av  = (alu_a[31] == op2[31]) && (sum[31] != alu_a[31]);
            end
            default: sum = {sh_c, op2};
        endcase
        alu_f    = sum[31:0];
        alu_nzcv = {sum[31], sum[31:0] == 32'd0, sum[32], av};
    end

    typedef struct {
        logic exec;
        logic ill;
        int   cyc;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    logic [31:0] exp_regs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Retirement monitor
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("executed", {31'd0, executed}, {31'd0, e.exec});
                chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the EXEC cycle of the accepted instruction.
    task automatic issue(input logic [31:0] ins, input logic ex, input logic il,
                         input logic expect_done, input logic hold);
        int n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        tick();
        if (expect_done) sb.push_back('{exec: ex, ill: il, cyc: cyc + 1});
        if (!hold) instr_valid = 1'b0;
        chk("ready_exec", {31'd0, instr_ready}, 32'd0);
    endtask

    task automatic finish_instr();
        tick();
        chk("ready_wb", {31'd0, instr_ready}, 32'd0);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic chk_reg(input int idx, input logic [31:0] exp);
        dbg_addr = idx[3:0];
        #1;
        chk($sformatf("R%0d", idx), dbg_data, exp);
    endtask

    task automatic chk_all_regs();
        for (int i = 0; i < 16; i++) chk_reg(i, exp_regs[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        dbg_addr = 4'd0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset_flags", {28'd0, flags}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_shift_op", {29'd0, shift_op}, 32'd0);
        chk("reset_alu_op", {28'd0, alu_op}, 32'd0);
        chk_reg(1, 32'd0);

        // MOV R1,#0xFF ROR 8
        issue(32'hE3A014FF, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("mov_alu_a", alu_a, 32'd0);
        chk("mov_shift_data", shift_data, 32'h0000_00FF);
        chk("mov_shift_num", {24'd0, shift_num}, 32'd8);
        chk("mov_shift_op", {29'd0, shift_op}, 32'd7);
        chk("mov_alu_op", {28'd0, alu_op}, 32'd13);
        finish_instr();
        exp_regs[1] = 32'hFF00_0000;
        chk_reg(1, 32'hFF00_0000);
        chk("mov_flags", {28'd0, flags}, 32'h0);

        // ADDS R2,R1,R1
        issue(32'hE0912001, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("adds_alu_a", alu_a, 32'hFF00_0000);
        chk("adds_shift_data", shift_data, 32'hFF00_0000);
        chk("adds_shift_num", {24'd0, shift_num}, 32'd0);
        chk("adds_shift_op", {29'd0, shift_op}, 32'd0);
        finish_instr();
        exp_regs[2] = 32'hFE00_0000;
        chk_reg(2, 32'hFE00_0000);
        chk("adds_flags", {28'd0, flags}, 32'hA);

        // MOVEQ R3,#1 with Z clear
        issue(32'h03A03001, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_instr();
        chk_reg(3, 32'd0);
        chk("moveq_flags", {28'd0, flags}, 32'hA);

        // CMP R1,R1
        issue(32'hE1510001, 1'b1, 1'b0, 1'b1, 1'b0);
        finish_instr();
        chk_all_regs();
        chk("cmp_flags", {28'd0, flags}, 32'h6);

        // LDR encoding with instr_valid held through EXEC and WB
        d0 = done_cnt;
        issue(32'hE5912000, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("ldr_ready_wb", {31'd0, instr_ready}, 32'd0);
        tick();
        instr_valid = 1'b0;
        repeat (4) tick();
        chk("ldr_single_accept", done_cnt - d0, 32'd1);
        chk_all_regs();
        chk("ldr_flags", {28'd0, flags}, 32'h6);

        // Reset during WB of ADDS aborts retirement
        d0 = done_cnt;
        issue(32'hE0912001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #2;
        chk("abort_no_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b0;
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_flags", {28'd0, flags}, 32'd0);
        chk_reg(2, 32'd0);
        chk_reg(1, 32'd0);
        tick();
        chk("abort_done_cnt", done_cnt - d0, 32'd0);
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'd0;

        // Recovery after abort
        issue(32'hE3A014FF, 1'b1, 1'b0, 1'b1, 1'b0);
        finish_instr();
        chk_reg(1, 32'hFF00_0000);
        chk_reg(2, 32'd0);

        repeat (2) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
